operand_fetch: RTL
==================

Name: operand_fetch

Overview:
Decode/operand-fetch stage that sits directly upstream of the 32x32 register file (one combinational read port, one synchronous write port).
- Accepts an instruction, then drives the file's read-select for rs1 and then rs2 over two consecutive cycles, and presents both operands downstream with a valid/ready handshake.
- Owns the file's write port on behalf of writeback. Blocks writes to x0, forces x0 reads to zero, and bypasses same-cycle writeback data.

Parameters:
XLEN, 32, data and instruction width; must be 32.
AW, 5, register address width; must be 5.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept instruction
in_instr  in  XLEN  instruction word; rs1=[19:15], rs2=[24:20]
in_pc  in  XLEN  PC of instruction, passed through
out_valid  out  1  operands valid
out_ready  in  1  downstream accepts
out_instr  out  XLEN  latched instruction
out_pc  out  XLEN  latched PC
out_rs1_val  out  XLEN  rs1 operand
out_rs2_val  out  XLEN  rs2 operand
wb_valid  in  1  writeback request
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback data
rf_readnum  out  AW  register file read select
rf_data_out  in  XLEN  register file read data (combinational)
rf_write  out  1  register file write enable
rf_writenum  out  AW  register file write select
rf_data_in  out  XLEN  register file write data

Behaviour:
- Reset (async, reset=1): state=IDLE; out_valid, out_instr, out_pc, out_rs1_val and out_rs2_val are all 0. in_ready=0 while reset is high. Reset mid-transaction discards it immediately; no partial output.
- FSM states: IDLE, RD1, RD2, HOLD.
  - IDLE: in_ready=1. When in_valid=1, latch in_instr/in_pc and go to RD1.
  - RD1: rf_readnum=rs1. Capture the rs1 operand into out_rs1_val, go to RD2.
  - RD2: rf_readnum=rs2. Capture the rs2 operand into out_rs2_val, go to HOLD.
  - HOLD: out_valid=1, in_ready=out_ready.
    - If out_ready and in_valid: latch the new instruction and go to RD1 (out_valid falls).
    - If out_ready only: go to IDLE.
    - Otherwise stay in HOLD.
- rf_readnum=0 in IDLE and HOLD.
- Latency: with acceptance on edge E0, out_valid is high after edge E0+2. Peak throughput is one instruction per 3 cycles.
- Operand select at capture:
  - register index 0 -> 0;
  - else if wb_valid and wb_rd equals the index -> wb_data (bypass, because the file returns the old value in the write cycle);
  - else -> rf_data_out.
- HOLD coherence: each cycle in HOLD, if wb_valid, wb_rd!=0 and wb_rd matches rs1 (or rs2), update out_rs1_val (or out_rs2_val) with wb_data. If rs1==rs2, update both. out_instr and out_pc stay stable.
- Write path (combinational): rf_write = wb_valid & (wb_rd!=0); rf_writenum = wb_rd; rf_data_in = wb_data. Writes to x0 are silently dropped. Writeback is never stalled and is independent of FSM state.
- Outputs out_instr, out_pc and the operands are registered. Their values are don't-care to consumers unless out_valid=1, but they hold their last value otherwise.

Test Plan:
1. Assert reset mid-clock -> all outputs 0 and in_ready=0 immediately without a clock edge; release -> in_ready=1 in IDLE.
2. Write x5=0x12345678 and x6=0x0000CAFE via wb. Present in_instr=0x006283B3 (add x7,x5,x6) with in_pc=0x100 -> rf_readnum=5 then 6. out_valid is high 2 edges after acceptance with out_rs1_val=0x12345678, out_rs2_val=0x0000CAFE, out_pc=0x100.
3. wb_valid=1, wb_rd=0, wb_data=0xFFFFFFFF -> rf_write=0. Then an instruction with rs1=0, rs2=0 -> both operands 0.
4. Bypass: wb writes x5=0x0000AAAA in the same cycle as RD1 for rs1=5 -> out_rs1_val=0x0000AAAA.
5. Backpressure: hold out_ready=0 for 4 cycles in HOLD; write x6=0x55 during that time -> out_rs2_val=0x55 the next cycle, out_valid stays high, other outputs are stable. Then out_ready=1 with in_valid=1 -> the next instruction is accepted on the same edge and the state goes to RD1.
6. Assert reset during RD2 -> out_valid stays 0 and the state returns to IDLE; the following transaction from test 2 completes with correct values.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode/operand-fetch stage driving a 32x32 register file.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [AW-1:0]   rf_readnum,
   input  logic [XLEN-1:0] rf_data_out,
   output logic            rf_write,
   output logic [AW-1:0]   rf_writenum,
   output logic [XLEN-1:0] rf_data_in
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD1  = 2'd1,
      RD2  = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_accept;
   logic [AW-1:0]     w_rs1;
   logic [AW-1:0]     w_rs2;
   logic [XLEN-1:0]   w_sel_val;

   assign w_rs1 = out_instr[19:15];
   assign w_rs2 = out_instr[24:20];

   // Writeback owns the write port unconditionally; x0 writes are dropped.
   assign rf_write    = wb_valid & (wb_rd != '0);
   assign rf_writenum = wb_rd;
   assign rf_data_in  = wb_data;

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      rf_readnum   = '0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = RD1;
            end
         end
         RD1: begin
            rf_readnum   = w_rs1;
            w_next_state = RD2;
         end
         RD2: begin
            rf_readnum   = w_rs2;
            w_next_state = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_accept     = 1'b1;
                  w_next_state = RD1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
      // The state is already IDLE while reset is high; ready must still read 0.
      if (reset) begin
         in_ready = 1'b0;
         w_accept = 1'b0;
      end
   end

   // The file returns the old value during its write cycle, hence the bypass.
   always_comb begin
      if (rf_readnum == '0) begin
         w_sel_val = '0;
      end else if (wb_valid && (wb_rd == rf_readnum)) begin
         w_sel_val = wb_data;
      end else begin
         w_sel_val = rf_data_out;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         out_instr   <= '0;
         out_pc      <= '0;
         out_rs1_val <= '0;
         out_rs2_val <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
         end
         case (r_state)
            RD1: out_rs1_val <= w_sel_val;
            RD2: out_rs2_val <= w_sel_val;
            HOLD: begin
               // Keep held operands coherent with writes landing while stalled.
               if (rf_write && (wb_rd == w_rs1)) begin
                  out_rs1_val <= wb_data;
               end
               if (rf_write && (wb_rd == w_rs2)) begin
                  out_rs2_val <= wb_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
